// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pkg
//  Purpose  : Shared constants and FSM state encoding for the sequential
//             radix-2 Booth multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Operand width the fixed 8-bit booth_substep supports.
    localparam int c_default_width = 8;

    // Controller states. The width is given explicitly so that the register
    // stays two bits wide whatever the tool's enum default is.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_substep.sv
`default_nettype none
// ============================================================================
//  Module   : eight_bit_adder_subtractor
//  Purpose  : 8-bit modulo-256 add/subtract with a signed-overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module eight_bit_adder_subtractor (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] sum,
    output logic       overflow
);

    logic [7:0] w_b_eff;

    // Subtraction is a + ~b + 1. The +1 enters as the carry-in.
    assign w_b_eff  = b ^ {8{sub}};
    assign sum      = a + w_b_eff + {7'd0, sub};
    // Signed overflow: the operands share a sign and the result has the other sign.
    assign overflow = (a[7] == w_b_eff[7]) && (sum[7] != a[7]);

endmodule : eight_bit_adder_subtractor

// ============================================================================
//  Module   : booth_substep
//  Purpose  : One combinational radix-2 Booth step on {acc, Q, q0}. It makes a
//             conditional add or subtract of B, then an arithmetic right shift.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_substep (
    input  logic [7:0] acc,
    input  logic [7:0] Q,
    input  logic       q0,
    input  logic [7:0] B,
    output logic [7:0] next_acc,
    output logic [7:0] next_Q,
    output logic       q0_next
);

    logic       w_add_en;
    logic       w_sub;
    logic [7:0] w_sum;
    logic       w_ovf;
    logic       w_sign;

    // The bit pair 10 subtracts B and 01 adds B. The pairs 00 and 11 add zero.
    assign w_add_en = Q[0] ^ q0;
    assign w_sub    = Q[0] & ~q0;

    eight_bit_adder_subtractor u_addsub (
        .a        (acc),
        .b        (B & {8{w_add_en}}),
        .sub      (w_sub),
        .sum      (w_sum),
        .overflow (w_ovf)
    );

    // The 8-bit sum wraps modulo 256. When it overflows (for example
    // 0 - (-128)), sum[7] is no longer the true sign. XOR with the overflow flag
    // gives the real sign, so the shift stays exact and the -128 corner cases
    // still produce correct products.
    assign w_sign   = w_sum[7] ^ w_ovf;
    assign next_acc = {w_sign, w_sum[7:1]};
    assign next_Q   = {w_sum[0], Q[7:1]};
    assign q0_next  = Q[0];

endmodule : booth_substep
`default_nettype wire

// File: rtl/booth_seq_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : booth_seq_multiplier_ctrl
//  Purpose  : Runs one shared booth_substep for WIDTH cycles to produce a
//             signed WIDTH x WIDTH -> 2*WIDTH product. Operands arrive on a
//             valid/ready input port and the product leaves on a valid/ready
//             output port.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_seq_multiplier_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = c_default_width,       // must be 8 (substep is 8-bit)
    parameter int CNT_W = $clog2(WIDTH) + 1      // derived; leave at default
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic               r_q_m1;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_next_acc;
    logic [WIDTH-1:0]   w_next_q;
    logic               w_q0_next;

    logic               w_load;
    logic               w_step;
    logic               w_last_step;

    // A single Booth step instance is shared by every cycle of the run.
    booth_substep u_step (
        .acc      (r_acc),
        .Q        (r_q),
        .q0       (r_q_m1),
        .B        (r_b),
        .next_acc (w_next_acc),
        .next_Q   (w_next_q),
        .q0_next  (w_q0_next)
    );

    // State register. rst takes priority over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, handshake outputs and datapath enables.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                // The run always takes WIDTH steps. There is no early exit.
                if (r_cnt == c_last_cnt) begin
                    w_last_step  = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // No skid path: in_ready stays low until DONE hands off to IDLE.
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand load, per-step register update and product capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_q_m1    <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_acc  <= '0;
            r_q    <= multiplier;
            r_b    <= multiplicand;
            r_q_m1 <= 1'b0;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_acc  <= w_next_acc;
            r_q    <= w_next_q;
            r_q_m1 <= w_q0_next;
            r_cnt  <= r_cnt + 1'b1;
            // The product is captured from the final step on the same edge,
            // so it is valid on the first DONE cycle.
            if (w_last_step) begin
                r_product <= {w_next_acc, w_next_q};
            end
        end
    end

    assign product = r_product;

endmodule : booth_seq_multiplier_ctrl
`default_nettype wire

// File: tb/tb_booth_seq_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_seq_multiplier_ctrl
//  Purpose  : Self-checking bench for booth_seq_multiplier_ctrl. It runs
//             directed handshake and corner cases, then a back-to-back
//             randomised stream compared against a signed multiply model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_multiplier_ctrl;

    localparam int c_width = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [c_width-1:0]   multiplicand;
    logic [c_width-1:0]   multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*c_width-1:0] product;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    booth_seq_multiplier_ctrl #(.WIDTH(c_width)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a plain signed integer multiply, truncated to 16 bits.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. hold = number of extra DONE cycles with out_ready=0.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input logic ordy, input int hold);
        int n;
        logic [15:0] held;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        out_ready    = ordy;
        tick();
        in_valid     = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 32'd8);
        check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
        held = product;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_product"}, {16'd0, product}, {16'd0, held});
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_fall"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        int sent;
        int got;
        int cyc;
        logic in_fire;
        logic out_fire;
        logic [15:0] q[$];
        logic [15:0] expv;

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // rst wins over an operand handshake at the same edge.
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        check("rst_prio_ready", {31'd0, in_ready}, 32'd1);

        // Basic op. out_ready is held high through RUN and must have no effect there.
        do_op("basic", 8'd3, 8'd5, 16'h000F, 1'b1, 0);
        // Signed and corner cases.
        do_op("neg7x6", 8'hF9, 8'd6, 16'hFFD6, 1'b0, 0);
        do_op("127xm128", 8'd127, 8'h80, 16'hC080, 1'b0, 0);
        do_op("m128xm128", 8'h80, 8'h80, 16'h4000, 1'b0, 0);
        do_op("0xm1", 8'd0, 8'hFF, 16'h0000, 1'b0, 0);
        // Backpressure: 5 held DONE cycles.
        do_op("bp", 8'd11, 8'hF3, 16'hFF71, 1'b0, 5);

        // in_valid while busy is ignored.
        in_valid     = 1'b1;
        multiplicand = 8'd4;
        multiplier   = 8'd4;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        in_valid     = 1'b1;
        multiplicand = 8'd2;
        multiplier   = 8'd2;
        tick();
        in_valid = 1'b0;
        n = 4;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check("ignore_latency", n, 32'd8);
        check("ignore_product", {16'd0, product}, 32'h0010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("ignore_no_second", cnt, 32'd0);

        // Reset in the middle of a run.
        in_valid     = 1'b1;
        multiplicand = 8'd5;
        multiplier   = 8'd5;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("abort_no_pulse", cnt, 32'd0);
        do_op("post_rst", 8'd9, 8'hFD, 16'hFFE5, 1'b0, 0);

        // Back-to-back random stream with in_valid high and random out_ready.
        sent = 0;
        got  = 0;
        cyc  = 0;
        in_valid     = 1'b1;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        out_ready    = 1'($urandom_range(0, 1));
        while (got < 256 && cyc < 8000) begin
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                check("b2b_result_expected", {31'd0, (q.size() != 0)}, 32'd1);
                if (q.size() != 0) begin
                    expv = q.pop_front();
                    check("b2b_product", {16'd0, product}, {16'd0, expv});
                end
                got++;
            end
            if (in_fire) begin
                q.push_back(ref_mul(multiplicand, multiplier));
                sent++;
            end
            tick();
            cyc++;
            if (in_fire) begin
                if (sent < 256) begin
                    multiplicand = 8'($urandom);
                    multiplier   = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        check("b2b_sent", sent, 32'd256);
        check("b2b_got", got, 32'd256);
        check("b2b_queue_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_booth_seq_multiplier_ctrl
`default_nettype wire
